// File: rtl/kg_patch_pkg.sv
// Shared types and default widths for the kugelblitz byte-patch scheduler.
package kg_patch_pkg;

  localparam int KG_REQ_COUNT    = 2;
  localparam int KG_OFFSET_WIDTH = 6;
  localparam int KG_BYTE_WIDTH   = 8;
  localparam int KG_COUNT_WIDTH  = 16;
  localparam int KG_FIFO_DEPTH   = 4;
  localparam int KG_SRC_WIDTH    = (KG_REQ_COUNT > 1) ? $clog2(KG_REQ_COUNT) : 1;

  typedef struct packed {
    logic [KG_SRC_WIDTH-1:0]    src;
    logic [KG_OFFSET_WIDTH-1:0] offset;
    logic [KG_BYTE_WIDTH-1:0]   data;
    logic [KG_COUNT_WIDTH-1:0]  count;
  } patch_cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } patch_state_e;

  function automatic int wrap_inc(input int v, input int n);
    if (v + 1 >= n) begin
      return 0;
    end else begin
      return v + 1;
    end
  endfunction

endpackage

// File: rtl/kg_patch_fifo.sv
// Synchronous command FIFO for patch commands; clr_i empties it at the next edge.
module kg_patch_fifo
  import kg_patch_pkg::*;
#(
  parameter int DEPTH = KG_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       push_i,
  input  patch_cmd_t wdata_i,
  input  logic       pop_i,
  output patch_cmd_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  patch_cmd_t     mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;
  logic           do_push_s;
  logic           do_pop_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop_i && !empty_o && !clr_i;
  // A pop frees the slot, so a push alongside it is legal even when full.
  assign do_push_s = push_i && (!full_o || do_pop_s) && !clr_i;
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/kugelblitz_patch_sched.sv
// Round-robin byte-patch scheduler: arbiter, command queue and frame-gated apply FSM.
// Define KG_PATCH_STATS_EN to implement the stat_frames counter (tied to 0 otherwise).
module kugelblitz_patch_sched
  import kg_patch_pkg::*;
#(
  parameter int REQ_COUNT    = KG_REQ_COUNT,
  parameter int OFFSET_WIDTH = KG_OFFSET_WIDTH,
  parameter int BYTE_WIDTH   = KG_BYTE_WIDTH,
  parameter int COUNT_WIDTH  = KG_COUNT_WIDTH,
  parameter int FIFO_DEPTH   = KG_FIFO_DEPTH,
  parameter int SRC_WIDTH    = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REQ_COUNT-1:0]              req_valid,
  output logic [REQ_COUNT-1:0]              req_ready,
  input  logic [REQ_COUNT*OFFSET_WIDTH-1:0] req_offset,
  input  logic [REQ_COUNT*BYTE_WIDTH-1:0]   req_data,
  input  logic [REQ_COUNT*COUNT_WIDTH-1:0]  req_count,
  input  logic                              flush,
  input  logic                              mon_tvalid,
  input  logic                              mon_tready,
  input  logic                              mon_tlast,
  output logic                              patch_en,
  output logic [OFFSET_WIDTH-1:0]           patch_offset,
  output logic [BYTE_WIDTH-1:0]             patch_data,
  output logic [SRC_WIDTH-1:0]              patch_src,
  output logic                              busy,
  output logic [31:0]                       stat_frames
);

  patch_cmd_t               wr_cmd_s;
  patch_cmd_t               head_cmd_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic                     any_s;
  logic                     accept_s;
  logic                     pop_s;
  logic                     beat_s;
  logic                     first_beat_s;
  logic [SRC_WIDTH-1:0]     win_s;
  logic [SRC_WIDTH-1:0]     idx_s;
  logic [SRC_WIDTH:0]       sum_s;
  logic [SRC_WIDTH-1:0]     ptr_q;
  logic [SRC_WIDTH-1:0]     ptr_d;
  patch_state_e             state_q;
  logic                     in_frame_q;
  logic [COUNT_WIDTH-1:0]   remaining_q;
  logic [OFFSET_WIDTH-1:0]  offset_q;
  logic [BYTE_WIDTH-1:0]    data_q;
  logic [SRC_WIDTH-1:0]     src_q;

  // Search from the pointer upward, wrapping, for the first valid requester.
  always_comb begin
    any_s = 1'b0;
    win_s = '0;
    idx_s = '0;
    sum_s = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      sum_s = {1'b0, ptr_q} + (SRC_WIDTH+1)'(k);
      if (sum_s >= (SRC_WIDTH+1)'(REQ_COUNT)) begin
        sum_s = sum_s - (SRC_WIDTH+1)'(REQ_COUNT);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[SRC_WIDTH-1:0];
      if (!any_s && req_valid[idx_s]) begin
        any_s = 1'b1;
        win_s = idx_s;
      end else begin
        any_s = any_s;
      end
    end
  end

  assign accept_s  = any_s && !fifo_full_s && !flush && rst_n;
  assign req_ready = accept_s ? (REQ_COUNT'(1) << win_s) : '0;
  assign ptr_d     = SRC_WIDTH'(wrap_inc(int'(win_s), REQ_COUNT));

  always_comb begin
    wr_cmd_s        = '0;
    wr_cmd_s.src    = win_s;
    wr_cmd_s.offset = req_offset[win_s*OFFSET_WIDTH +: OFFSET_WIDTH];
    wr_cmd_s.data   = req_data[win_s*BYTE_WIDTH +: BYTE_WIDTH];
    wr_cmd_s.count  = req_count[win_s*COUNT_WIDTH +: COUNT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept_s) begin
      ptr_q <= ptr_d;
    end else begin
      ptr_q <= ptr_q;
    end
  end

  kg_patch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (flush),
    .push_i  (accept_s),
    .wdata_i (wr_cmd_s),
    .pop_i   (pop_s),
    .rdata_o (head_cmd_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign beat_s = mon_tvalid && mon_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_frame_q <= 1'b0;
    end else if (beat_s) begin
      in_frame_q <= !mon_tlast;
    end else begin
      in_frame_q <= in_frame_q;
    end
  end

  // Patching only opens between frames, so a command never changes mid-frame.
  assign pop_s        = (state_q == ST_IDLE) && !fifo_empty_s && !flush;
  assign patch_en     = (state_q == ST_ACTIVE) && !in_frame_q && !flush && rst_n;
  assign first_beat_s = patch_en && beat_s;
  assign busy         = (state_q == ST_ACTIVE) || !fifo_empty_s;
  assign patch_offset = offset_q;
  assign patch_data   = data_q;
  assign patch_src    = src_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      offset_q    <= '0;
      data_q      <= '0;
      src_q       <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s && (head_cmd_s.count != '0)) begin
            state_q     <= ST_ACTIVE;
            remaining_q <= head_cmd_s.count;
            offset_q    <= head_cmd_s.offset;
            data_q      <= head_cmd_s.data;
            src_q       <= head_cmd_s.src;
          end else begin
            state_q     <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (first_beat_s) begin
            remaining_q <= remaining_q - COUNT_WIDTH'(1);
            if (remaining_q == COUNT_WIDTH'(1)) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_ACTIVE;
            end
          end else begin
            state_q <= ST_ACTIVE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef KG_PATCH_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q <= 32'd0;
    end else if (first_beat_s) begin
      stat_q <= stat_q + 32'd1;
    end else begin
      stat_q <= stat_q;
    end
  end

  assign stat_frames = stat_q;
`else
  assign stat_frames = 32'd0;
`endif

endmodule

// File: tb/tb_kugelblitz_patch_sched.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_kugelblitz_patch_sched;

`ifdef KG_PATCH_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req_offset;
  logic [15:0] req_data;
  logic [31:0] req_count;
  logic        flush;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;
  logic        patch_en;
  logic [5:0]  patch_offset;
  logic [7:0]  patch_data;
  logic [0:0]  patch_src;
  logic        busy;
  logic [31:0] stat_frames;

  always #5 clk = ~clk;

  kugelblitz_patch_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_offset   (req_offset),
    .req_data     (req_data),
    .req_count    (req_count),
    .flush        (flush),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .mon_tlast    (mon_tlast),
    .patch_en     (patch_en),
    .patch_offset (patch_offset),
    .patch_data   (patch_data),
    .patch_src    (patch_src),
    .busy         (busy),
    .stat_frames  (stat_frames)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int src;
    int off;
    int data;
    int cnt;
  } mcmd_t;

  mcmd_t       mq[$];
  bit          m_active;
  int          m_rem, m_off, m_data, m_src, m_ptr;
  bit          m_in_frame;
  logic [31:0] m_stat;

  int pe_count;
  int acc_srcs[$];
  int pat_srcs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0; m_rem = 0; m_off = 0; m_data = 0; m_src = 0; m_ptr = 0;
    m_in_frame = 1'b0; m_stat = 32'd0;
  endtask

  // One clock: compare DUT against the model, advance the model, move to the next negedge.
  task automatic cycle();
    int win; bit any; bit acc; bit pe; bit beat;
    logic [1:0] er; logic [31:0] es; mcmd_t c;
    #1;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_patch_en", 64'(patch_en), 64'(0));
      model_reset();
    end else begin
      any = 1'b0; win = 0;
      for (int k = 0; k < 2; k++) begin
        int idx;
        idx = (m_ptr + k) % 2;
        if (!any && req_valid[idx]) begin any = 1'b1; win = idx; end
      end
      acc = any && (mq.size() < 4) && !flush;
      er  = acc ? (2'b01 << win) : 2'b00;
      pe  = m_active && !m_in_frame && !flush;
      es  = STATS_ON ? m_stat : 32'd0;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("patch_en", 64'(patch_en), 64'(pe));
      chk("patch_offset", 64'(patch_offset), 64'(m_off));
      chk("patch_data", 64'(patch_data), 64'(m_data));
      chk("patch_src", 64'(patch_src), 64'(m_src));
      chk("busy", 64'(busy), 64'(m_active || (mq.size() > 0)));
      chk("stat_frames", 64'(stat_frames), 64'(es));
      beat = mon_tvalid && mon_tready;
      if (patch_en && beat) begin
        pe_count++;
        pat_srcs.push_back(int'(patch_src));
      end
      if ((req_ready & req_valid) != 2'b00) acc_srcs.push_back(req_ready[1] ? 1 : 0);
      if (flush) begin
        mq.delete();
        m_active = 1'b0;
      end else begin
        if (!m_active && mq.size() > 0) begin
          c = mq.pop_front();
          if (c.cnt != 0) begin
            m_active = 1'b1; m_rem = c.cnt; m_off = c.off; m_data = c.data; m_src = c.src;
          end
        end else if (pe && beat) begin
          m_rem--;
          m_stat = m_stat + 32'd1;
          if (m_rem == 0) m_active = 1'b0;
        end
        if (acc) begin
          c.src  = win;
          c.off  = int'(req_offset[win*6 +: 6]);
          c.data = int'(req_data[win*8 +: 8]);
          c.cnt  = int'(req_count[win*16 +: 16]);
          mq.push_back(c);
          m_ptr = (win + 1) % 2;
        end
      end
      if (beat) m_in_frame = !mon_tlast;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic req1(input int i, input int off, input int dat, input int cnt);
    req_offset[i*6 +: 6]  = 6'(off);
    req_data[i*8 +: 8]    = 8'(dat);
    req_count[i*16 +: 16] = 16'(cnt);
    req_valid    = 2'b00;
    req_valid[i] = 1'b1;
    cycle();
    req_valid    = 2'b00;
  endtask

  task automatic frame(input int n);
    for (int b = 0; b < n; b++) begin
      mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = (b == n - 1);
      cycle();
    end
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_offset = 12'd0; req_data = 16'd0; req_count = 32'd0;
    flush = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tlast = 1'b0;
    model_reset();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    chk("reset_patch_offset", 64'(patch_offset), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_stat", 64'(stat_frames), 64'(0));
    idle(1);

    // Single command over three frames
    req1(0, 12, 8'hAA, 2);
    idle(2);
    pe_count = 0;
    frame(4); frame(4);
    chk("t1_two_patched", 64'(pe_count), 64'(2));
    chk("t1_offset", 64'(patch_offset), 64'(12));
    chk("t1_data", 64'(patch_data), 64'(8'hAA));
    frame(4);
    chk("t1_third_unpatched", 64'(pe_count), 64'(2));
    chk("t1_stat", 64'(stat_frames), 64'(STATS_ON ? 2 : 0));

    // Command arriving mid-frame
    pe_count = 0;
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0;
    cycle();
    req1(1, 5, 8'h55, 1);
    cycle();
    mon_tlast = 1'b1;
    cycle();
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    cycle();
    chk("t2_no_patch_in_frame", 64'(pe_count), 64'(0));
    frame(4);
    chk("t2_next_frame_patched", 64'(pe_count), 64'(1));
    chk("t2_src", 64'(patch_src), 64'(1));

    // Round robin until the queue is full
    req_offset = {6'd2, 6'd1}; req_data = {8'h22, 8'h11}; req_count = {16'd1, 16'd1};
    acc_srcs.delete();
    req_valid = 2'b11;
    idle(8);
    chk("t3_full_ready_low", 64'(req_ready), 64'(0));
    req_valid = 2'b00;
    chk("t3_accept_count", 64'(acc_srcs.size()), 64'(5));
    for (int i = 0; i < acc_srcs.size() && i < 5; i++) chk("t3_accept_order", 64'(acc_srcs[i]), 64'(i % 2));
    pat_srcs.delete();
    repeat (6) frame(2);
    chk("t3_patch_count", 64'(pat_srcs.size()), 64'(5));
    for (int i = 0; i < pat_srcs.size() && i < 5; i++) chk("t3_patch_order", 64'(pat_srcs[i]), 64'(i % 2));

    // Backpressure stall on a first beat
    req1(0, 3, 8'h33, 2);
    idle(2);
    pe_count = 0;
    mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_stall_patch_en", 64'(patch_en), 64'(1));
    end
    mon_tready = 1'b1;
    cycle(); cycle(); cycle();
    mon_tlast = 1'b1;
    cycle();
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    cycle();
    frame(4);
    chk("t4_both_frames", 64'(pe_count), 64'(2));
    chk("t4_idle_after", 64'(busy), 64'(0));

    // Count 0 command is discarded
    pe_count = 0;
    req1(0, 7, 8'h77, 0);
    idle(3);
    chk("t4_zero_not_busy", 64'(busy), 64'(0));
    frame(4);
    chk("t4_zero_no_patch", 64'(pe_count), 64'(0));

    // Flush while active with two queued
    req1(0, 9, 8'h99, 3);
    idle(2);
    req1(1, 10, 8'hA0, 1);
    req1(0, 11, 8'hB0, 1);
    flush = 1'b1; req_valid = 2'b01;
    #1;
    chk("t5_flush_ready", 64'(req_ready), 64'(0));
    cycle();
    flush = 1'b0; req_valid = 2'b00;
    chk("t5_busy_after_flush", 64'(busy), 64'(0));
    chk("t5_patch_en_after_flush", 64'(patch_en), 64'(0));
    pe_count = 0;
    frame(4);
    chk("t5_no_patch", 64'(pe_count), 64'(0));

    // Reset mid-frame
    req1(0, 4, 8'h44, 2);
    idle(2);
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; mon_tvalid = 1'b0;
    #1;
    chk("t6_rst_offset", 64'(patch_offset), 64'(0));
    chk("t6_rst_data", 64'(patch_data), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_stat", 64'(stat_frames), 64'(0));
    chk("t6_rst_patch_en", 64'(patch_en), 64'(0));
    cycle();
    req1(1, 6, 8'h66, 1);
    idle(2);
    mon_tvalid = 1'b1; mon_tlast = 1'b0;
    #1;
    chk("t6_first_beat_after_reset", 64'(patch_en), 64'(1));
    cycle();
    mon_tlast = 1'b1;
    cycle();
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      req_valid  = 2'($urandom_range(0, 3));
      req_offset = 12'($urandom);
      req_data   = 16'($urandom);
      req_count  = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
      mon_tvalid = ($urandom_range(0, 9) < 7);
      mon_tready = ($urandom_range(0, 9) < 7);
      mon_tlast  = ($urandom_range(0, 9) < 3);
      flush      = ($urandom_range(0, 39) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
